// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer.
package nibble_serial_alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int NIBBLES_DEFAULT = 4;

endpackage

// File: rtl/nibble_serial_alu_ctrl_add4.sv
// Combinational 4-bit ripple adder; exposes the carry into bit 3 for overflow detection.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    c3   = c[3];
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Wide add/subtract sequencer sharing one nibble adder over NIBBLES cycles, LSB nibble first.
// state   | meaning
// IDLE    | waiting for iSTART, result outputs held
// ADD     | one nibble processed per cycle
// DONE    | one-cycle oDONE pulse, then back to IDLE
module nibble_serial_alu_ctrl
  import nibble_serial_alu_ctrl_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                 iCLK_50,
  input  logic                 iRST_n,
  input  logic                 iSTART,
  input  logic                 iSUB,
  input  logic [4*NIBBLES-1:0] iA,
  input  logic [4*NIBBLES-1:0] iB,
  output logic [4*NIBBLES-1:0] oSUM,
  output logic                 oCARRY,
  output logic                 oOVF,
  output logic                 oBUSY,
  output logic                 oDONE,
  output logic [2:0]           oIDX
);

  localparam int W = 4 * NIBBLES;
  localparam logic [2:0] IDX_LAST = 3'(NIBBLES - 1);

  alu_state_e     state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic           carry_q, carry_d;
  logic [2:0]     idx_q, idx_d;
  logic           cout_q, cout_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;

  logic [3:0]     add_s;
  logic           add_c3, add_cout;
  logic [W-1:0]   res_shift;

  nibble_add4 u_add4 (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .s    (add_s),
    .c3   (add_c3),
    .cout (add_cout)
  );

  assign res_shift = {add_s, res_q[W-1:4]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          a_d     = iA;
          // subtract as A + ~B + 1: the +1 enters through the carry register
          b_d     = iSUB ? ~iB : iB;
          carry_d = iSUB;
          idx_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        res_d   = res_shift;
        a_d     = {4'b0, a_q[W-1:4]};
        b_d     = {4'b0, b_q[W-1:4]};
        carry_d = add_cout;
        idx_d   = idx_q + 3'd1;
        if (idx_q == IDX_LAST) begin
          sum_d   = res_shift;
          cout_d  = add_cout;
          ovf_d   = add_c3 ^ add_cout;
          idx_d   = 3'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= 3'd0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oSUM   = sum_q;
  assign oCARRY = cout_q;
  assign oOVF   = ovf_q;
  assign oBUSY  = busy_q;
  assign oDONE  = done_q;
  assign oIDX   = (state_q == ST_ADD) ? idx_q : 3'd0;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Scoreboard bench for nibble_serial_alu_ctrl (NIBBLES = 4) with directed, hand-computed vectors.
module tb_nibble_serial_alu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a, b;
  logic [15:0] sum;
  logic        carry, ovf, busy, done;
  logic [2:0]  idx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  int last_done = -1;
  bit gap_chk  = 0;
  bit prev_done = 0;

  logic [17:0] exp_q[$];

  nibble_serial_alu_ctrl #(.NIBBLES(4)) dut (
    .iCLK_50 (clk),
    .iRST_n  (rst_n),
    .iSTART  (start),
    .iSUB    (sub),
    .iA      (a),
    .iB      (b),
    .oSUM    (sum),
    .oCARRY  (carry),
    .oOVF    (ovf),
    .oBUSY   (busy),
    .oDONE   (done),
    .oIDX    (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge and pops the scoreboard on every oDONE.
  always @(negedge clk) begin
    logic [17:0] e;
    cyc++;
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_done = 0;
    end else begin
      if (prev_done) check("done_single_pulse", {31'b0, done}, 32'd0);
      prev_done = done;
      if (busy) begin
        check("idx_in_add", {29'b0, idx}, busy_cnt);
        busy_cnt++;
      end
      if (done) begin
        check("busy_cycles", busy_cnt, 32'd4);
        busy_cnt = 0;
        if (gap_chk && last_done >= 0) check("start_spacing", cyc - last_done, 32'd6);
        last_done = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sum",   {16'b0, sum},   {16'b0, e[17:2]});
          check("carry", {31'b0, carry}, {31'b0, e[1]});
          check("ovf",   {31'b0, ovf},   {31'b0, e[0]});
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", exp_q.size(), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                        input logic [15:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a = va; b = vb; sub = vs; start = 1'b1;
    exp_q.push_back({es, ec, eo});
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = ~vb; sub = ~vs;
    drain();
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        s;
    logic [15:0] es;
    logic        ec, eo;
  } vec_t;

  vec_t vecs[7];
  vec_t cont[3];

  initial begin
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    cont[0] = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0};
    cont[1] = '{16'h9000, 16'h1000, 1'b1, 16'h8000, 1'b1, 1'b0};
    cont[2] = '{16'hF0F0, 16'h0F10, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_sum",  {16'b0, sum}, 32'd0);
    check("rst_flags", {26'b0, carry, ovf, busy, done, 2'b0}, 32'd0);
    check("rst_idx",  {29'b0, idx}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].es, vecs[i].ec, vecs[i].eo);

    // iSTART held high: operands change every cycle, only accept-edge values matter
    gap_chk = 1; last_done = -1;
    @(negedge clk);
    a = cont[0].a; b = cont[0].b; sub = cont[0].s; start = 1'b1;
    exp_q.push_back({cont[0].es, cont[0].ec, cont[0].eo});
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        if (k == 2 && c == 0) start = 1'b0;
      end
      if (k < 2) begin
        @(negedge clk);
        a = cont[k+1].a; b = cont[k+1].b; sub = cont[k+1].s;
        exp_q.push_back({cont[k+1].es, cont[k+1].ec, cont[k+1].eo});
      end
    end
    drain();
    gap_chk = 0;

    run_op(vecs[6].a, vecs[6].b, vecs[6].s, vecs[6].es, vecs[6].ec, vecs[6].eo);

    // asynchronous reset mid-ADD: outputs clear at once, aborted op never completes
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sum",  {16'b0, sum}, 32'd0);
    check("arst_flags", {26'b0, carry, ovf, busy, done, 2'b0}, 32'd0);
    check("arst_idx",  {29'b0, idx}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_done_after_abort", {31'b0, done}, 32'd0);

    run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
